// File: rtl/sha_add_pkg.sv
// sha_add_pkg: shared constants and helpers for the SHA-256 multi-operand adder
package sha_add_pkg;
   localparam int SHA_WORD_W = 32;
   localparam int DEFAULT_CHUNK = 4;
   localparam int NUM_GROUPS = SHA_WORD_W / DEFAULT_CHUNK;
   // every 3:2 level turns each complete triple of words into a pair
   function automatic int csa_levels(input int n);
      int m, l;
      m = n;
      l = 0;
      while (m > 2) begin
         m = m - m / 3;
         l++;
      end
      return l;
   endfunction
endpackage

// File: rtl/sha_cla_group.sv
// sha_cla_group: one lookahead group of the final adder, local sum plus group generate/propagate
module sha_cla_group import sha_add_pkg::*; #(
   parameter int CHUNK = DEFAULT_CHUNK
) (
   input  logic [CHUNK-1:0] a,
   input  logic [CHUNK-1:0] b,
   input  logic             cin,
   output logic [CHUNK-1:0] sum,
   output logic             g,
   output logic             p
);
   logic [CHUNK:0] raw;
   assign raw = {1'b0, a} + {1'b0, b};
   assign g = raw[CHUNK];
   assign p = &(a ^ b);
   assign sum = raw[CHUNK-1:0] + CHUNK'(cin);
endmodule

// File: rtl/sha_multi_operand_adder.sv
// sha_multi_operand_adder: two-stage elastic modular sum of up to NUM_OPS words (CSA tree + grouped lookahead)
module sha_multi_operand_adder import sha_add_pkg::*; #(
   parameter int WIDTH = SHA_WORD_W,
   parameter int NUM_OPS = 5,
   parameter int CHUNK = DEFAULT_CHUNK,
   parameter int TAG_W = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [NUM_OPS*WIDTH-1:0] in_ops,
   input  logic [NUM_OPS-1:0]       in_en,
   input  logic [TAG_W-1:0]         in_tag,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [WIDTH-1:0]         out_sum,
   output logic [TAG_W-1:0]         out_tag
);
   localparam int GROUPS = WIDTH / CHUNK;
   localparam int LEVELS = csa_levels(NUM_OPS);
   logic s1_valid, s2_valid, adv, take, unused_cout;
   logic [WIDTH-1:0] red_s, red_c, s1_s, s1_c, sum;
   logic [TAG_W-1:0] s1_tag;
   logic [WIDTH-1:0] w [NUM_OPS];
   logic [WIDTH-1:0] nw [NUM_OPS];
   logic [GROUPS-1:0] g, p;
   logic [GROUPS:0] cy;
   assign adv = !s2_valid || out_ready;
   assign in_ready = !s1_valid || adv;
   assign take = in_valid && in_ready;
   assign out_valid = s2_valid;
   assign unused_cout = cy[GROUPS];
   // CSA tree: mask operands, then compress triples level by level until two words remain
   always_comb begin
      int n, t;
      n = NUM_OPS;
      t = 0;
      for (int i = 0; i < NUM_OPS; i++) w[i] = in_en[i] ? in_ops[i*WIDTH +: WIDTH] : '0;
      for (int j = 0; j < NUM_OPS; j++) nw[j] = '0;
      for (int l = 0; l < LEVELS; l++) begin
         t = n / 3;
         for (int j = 0; j < NUM_OPS; j++) nw[j] = '0;
         for (int k = 0; k < NUM_OPS / 3; k++)
            if (k < t) begin
               nw[2*k] = w[3*k] ^ w[3*k+1] ^ w[3*k+2];
               nw[2*k+1] = ((w[3*k] & w[3*k+1]) | (w[3*k] & w[3*k+2]) | (w[3*k+1] & w[3*k+2])) << 1;
            end
         for (int j = 0; j < NUM_OPS; j++) if (j >= 3*t && j < n) nw[j-t] = w[j];
         w = nw;
         n = n - t;
      end
      red_s = w[0];
      red_c = w[1];
   end
   // stage 1: capture the reduced pair on an input transfer, empty when it drains into stage 2
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         s1_valid <= 1'b0;
         s1_s <= '0;
         s1_c <= '0;
         s1_tag <= '0;
      end else if (take) begin
         s1_valid <= 1'b1;
         s1_s <= red_s;
         s1_c <= red_c;
         s1_tag <= in_tag;
      end else if (adv) s1_valid <= 1'b0;
   for (genvar j = 0; j < GROUPS; j++) begin : grp
      sha_cla_group #(.CHUNK(CHUNK)) u_grp (
         .a(s1_s[j*CHUNK +: CHUNK]),
         .b(s1_c[j*CHUNK +: CHUNK]),
         .cin(cy[j]),
         .sum(sum[j*CHUNK +: CHUNK]),
         .g(g[j]),
         .p(p[j])
      );
   end
   // group carry lookahead; the carry out of the top group is dropped (mod 2^WIDTH)
   always_comb begin
      cy[0] = 1'b0;
      for (int j = 0; j < GROUPS; j++) cy[j+1] = g[j] | (p[j] & cy[j]);
   end
   // stage 2: register the final sum whenever the output slot is free or being consumed
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         s2_valid <= 1'b0;
         out_sum <= '0;
         out_tag <= '0;
      end else if (adv) begin
         s2_valid <= s1_valid;
         if (s1_valid) begin
            out_sum <= sum;
            out_tag <= s1_tag;
         end
      end
endmodule

// File: tb/tb_sha_multi_operand_adder.sv
// tb_sha_multi_operand_adder: directed and random checks against an enabled-operand sum model
module tb_sha_multi_operand_adder;
   logic clk = 1'b0;
   logic reset, in_valid, in_ready, out_valid, out_ready;
   logic [159:0] in_ops;
   logic [4:0] in_en;
   logic [3:0] in_tag, out_tag;
   logic [31:0] out_sum;
   typedef struct {logic [31:0] sum; logic [3:0] tag;} exp_t;
   exp_t exp_q[$];
   int n_cmp = 0, n_bad = 0;
   bit a;
   sha_multi_operand_adder dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .in_ops(in_ops), .in_en(in_en), .in_tag(in_tag), .out_valid(out_valid),
      .out_ready(out_ready), .out_sum(out_sum), .out_tag(out_tag)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   function automatic logic [31:0] ref_sum(input logic [159:0] ops, input logic [4:0] en);
      logic [31:0] s = 0;
      for (int i = 0; i < 5; i++) if (en[i]) s = s + ops[i*32 +: 32];
      return s;
   endfunction
   task automatic tick(output bit acc);
      exp_t e;
      #1;
      acc = in_valid && in_ready;
      if (out_valid && out_ready) begin
         if (exp_q.size() == 0) chk("spurious", out_valid, 0);
         else begin
            e = exp_q.pop_front();
            chk("sum", out_sum, e.sum);
            chk("tag", out_tag, e.tag);
         end
      end
      if (acc) begin
         e.sum = ref_sum(in_ops, in_en);
         e.tag = in_tag;
         exp_q.push_back(e);
      end
      @(posedge clk);
      @(negedge clk);
   endtask
   task automatic drain();
      out_ready = 1;
      in_valid = 0;
      for (int i = 0; i < 50 && exp_q.size() != 0; i++) tick(a);
      chk("drain", exp_q.size(), 0);
   endtask
   task automatic rand_ops();
      for (int i = 0; i < 5; i++) in_ops[i*32 +: 32] = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFF : $urandom;
   endtask
   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end
   initial begin
      int acc_n, cyc;
      reset = 1; in_valid = 0; out_ready = 0; in_ops = '0; in_en = '0; in_tag = '0;
      #1;
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_sum", out_sum, 0);
      chk("rst_out_tag", out_tag, 0);
      @(negedge clk); @(negedge clk);
      reset = 0;
      // wrap-around and latency 2
      out_ready = 1; in_valid = 1; in_tag = 3; in_en = 5'h1f;
      in_ops = {32'h0, 32'h1, 32'h80000000, 32'h80000000, 32'h80000000};
      tick(a);
      chk("wrap_acc", a, 1);
      in_valid = 0;
      chk("wrap_lat1", out_valid, 0);
      tick(a);
      chk("wrap_lat2", out_valid, 1);
      chk("wrap_sum", out_sum, 32'h80000001);
      chk("wrap_tag", out_tag, 3);
      drain();
      // T2 mode then all five, back to back
      in_valid = 1; in_tag = 4; in_en = 5'b00011; in_ops = {5{32'h11111111}};
      tick(a);
      in_tag = 5; in_en = 5'h1f;
      tick(a);
      in_valid = 0;
      chk("t2_valid", out_valid, 1);
      chk("t2_sum", out_sum, 32'h22222222);
      tick(a);
      chk("t5_valid", out_valid, 1);
      chk("t5_sum", out_sum, 32'h55555555);
      drain();
      // carry ripple across every group
      in_valid = 1; in_tag = 6; in_ops = {32'h0, 32'h0, 32'h0, 32'h1, 32'hFFFFFFFF};
      tick(a);
      in_tag = 7; in_ops = {32'h0, 32'h0, 32'h0, 32'h1, 32'h0FFFFFFF};
      tick(a);
      in_valid = 0;
      chk("ripple0", out_sum, 32'h0);
      tick(a);
      chk("ripple1", out_sum, 32'h10000000);
      drain();
      // all slots masked still returns its tag
      in_valid = 1; in_tag = 9; in_en = 5'h0; rand_ops();
      tick(a);
      in_valid = 0;
      tick(a);
      chk("mask_sum", out_sum, 0);
      chk("mask_tag", out_tag, 9);
      drain();
      // backpressure: capacity two, output held, order preserved
      out_ready = 0; in_valid = 1; in_en = 5'h1f; in_tag = 1;
      in_ops = {32'h1, 32'h2, 32'h3, 32'h4, 32'h5};
      tick(a);
      chk("bp_acc1", a, 1);
      in_tag = 2; rand_ops();
      tick(a);
      chk("bp_acc2", a, 1);
      in_tag = 3;
      for (int i = 0; i < 3; i++) begin
         rand_ops();
         tick(a);
         chk("bp_ready", in_ready, 0);
         chk("bp_acc3", a, 0);
         chk("bp_hold_sum", out_sum, 32'hF);
         chk("bp_hold_tag", out_tag, 1);
      end
      out_ready = 1;
      a = 0;
      for (int i = 0; i < 10 && !a; i++) tick(a);
      chk("bp_acc3_late", a, 1);
      drain();
      // reset mid-flight
      out_ready = 0; in_valid = 1; in_tag = 10; rand_ops();
      tick(a);
      in_tag = 11; rand_ops();
      tick(a);
      in_valid = 0;
      #2 reset = 1;
      #1;
      chk("mid_rst_valid", out_valid, 0);
      chk("mid_rst_ready", in_ready, 1);
      chk("mid_rst_sum", out_sum, 0);
      exp_q.delete();
      @(negedge clk);
      reset = 0;
      out_ready = 1;
      for (int i = 0; i < 3; i++) begin
         tick(a);
         chk("rst_stale", out_valid, 0);
      end
      in_valid = 1; in_tag = 12; in_ops = {32'h10, 32'h20, 32'h30, 32'h40, 32'h50};
      tick(a);
      in_valid = 0;
      chk("rst_lat1", out_valid, 0);
      tick(a);
      chk("rst_lat2", out_valid, 1);
      chk("rst_new_sum", out_sum, 32'hF0);
      drain();
      // random traffic with random backpressure
      acc_n = 0;
      cyc = 0;
      while (acc_n < 10000 && cyc < 40000) begin
         out_ready = ($urandom_range(0, 3) != 0);
         in_valid = ($urandom_range(0, 4) != 0);
         in_en = 5'($urandom);
         in_tag = 4'($urandom);
         rand_ops();
         tick(a);
         if (a) acc_n++;
         cyc++;
      end
      chk("rand_count", acc_n, 10000);
      drain();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
